// File: rtl/ddr3_if_pkg.sv
// Shared types and default constants for the DDR3 burst sequencer.
`timescale 1ns/1ps
package ddr3_if_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int NUM_CH         = 4;
   localparam int AXI_LEN_W      = 8;
   localparam int DEF_ADDR_W     = 28;
   localparam int DEF_BURST_LEN  = 16;
   localparam int DEF_ADDR_STEP  = 128;
   localparam int DEF_FRAME_SPAN = 2097152;
   localparam int DEF_CH_STRIDE  = 2097152;

   // AXI len encoding of a burst of the given beat count.
   function automatic logic [AXI_LEN_W-1:0] axi_len(input int beats);
      return AXI_LEN_W'(beats - 1);
   endfunction

endpackage

// File: rtl/ddr3_burst_ctrl_if.sv
// Channel/arbiter/AXI bundle between the burst sequencer and its environment.
`timescale 1ns/1ps
interface ddr3_burst_ctrl_if #(
   parameter int ADDR_W = 28
) ();
   import ddr3_if_pkg::*;

   logic [NUM_CH-1:0]    ch_req;
   logic [NUM_CH-1:0]    ch_frame_rst;
   logic [NUM_CH-1:0]    arb_req;
   logic [NUM_CH-1:0]    arb_grant;
   logic [NUM_CH-1:0]    ch_data_en;
   logic [NUM_CH-1:0]    ch_ack;
   logic [ADDR_W-1:0]    axi_awaddr;
   logic [ADDR_W-1:0]    axi_araddr;
   logic [AXI_LEN_W-1:0] axi_awlen;
   logic [AXI_LEN_W-1:0] axi_arlen;
   logic                 axi_awvalid;
   logic                 axi_arvalid;
   logic                 axi_awready;
   logic                 axi_arready;
   logic                 axi_wvalid;
   logic                 axi_wlast;
   logic                 axi_wready;
   logic                 axi_rvalid;
   logic                 axi_rlast;
   logic                 busy;

   modport master (
      input  ch_req, ch_frame_rst, arb_grant,
      input  axi_awready, axi_arready, axi_wready, axi_rvalid, axi_rlast,
      output arb_req, ch_data_en, ch_ack,
      output axi_awaddr, axi_araddr, axi_awlen, axi_arlen,
      output axi_awvalid, axi_arvalid, axi_wvalid, axi_wlast, busy
   );

   modport slave (
      output ch_req, ch_frame_rst, arb_grant,
      output axi_awready, axi_arready, axi_wready, axi_rvalid, axi_rlast,
      input  arb_req, ch_data_en, ch_ack,
      input  axi_awaddr, axi_araddr, axi_awlen, axi_arlen,
      input  axi_awvalid, axi_arvalid, axi_wvalid, axi_wlast, busy
   );

endinterface

// File: rtl/ddr3_burst_ctrl_ch_addr_gen.sv
// Per-channel frame-buffer pointer: advances one step per burst, wraps at the
// end of the channel's span, and snaps back to base on a frame reset.
`timescale 1ns/1ps
module ch_addr_gen #(
   parameter int                ADDR_W = 28,
   parameter logic [ADDR_W-1:0] BASE   = '0,
   parameter int                SPAN   = 2097152,
   parameter int                STEP   = 128
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_frame_rst,
   input  logic              i_advance,
   output logic [ADDR_W-1:0] o_ptr
);
   localparam int              W1    = ADDR_W + 1;
   localparam logic [W1-1:0]   LIMIT = {1'b0, BASE} + W1'(SPAN);

   logic [ADDR_W-1:0] r_ptr;
   logic [W1-1:0]     w_next;

   // One extra bit so the limit compare cannot overflow at the top channel.
   assign w_next = {1'b0, r_ptr} + W1'(STEP);
   assign o_ptr  = r_ptr;

   // Pointer register; frame reset takes priority over a same-cycle advance.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= BASE;
      end else if (i_frame_rst) begin
         r_ptr <= BASE;
      end else if (i_advance) begin
         r_ptr <= (w_next >= LIMIT) ? BASE : w_next[ADDR_W-1:0];
      end else begin
         r_ptr <= r_ptr;
      end
   end

endmodule

// File: rtl/ddr3_burst_ctrl.sv
// Burst sequencer: takes one arbiter grant, runs one fixed-length AXI burst
// for that channel, then acks the channel and advances its frame pointer.
`timescale 1ns/1ps
module ddr3_burst_ctrl
   import ddr3_if_pkg::*;
#(
   parameter int          ADDR_W     = DEF_ADDR_W,
   parameter int          BURST_LEN  = DEF_BURST_LEN,
   parameter int          ADDR_STEP  = DEF_ADDR_STEP,
   parameter int          FRAME_SPAN = DEF_FRAME_SPAN,
   parameter int          CH_STRIDE  = DEF_CH_STRIDE,
   parameter logic [3:0]  WR_MASK    = 4'b0011
) (
   input  logic             clk,
   input  logic             rst_n,
   ddr3_burst_ctrl_if.master bus
);
   localparam logic [AXI_LEN_W-1:0] BEAT_LAST = axi_len(BURST_LEN);

   state_e               r_state;
   logic [NUM_CH-1:0]    r_sel;
   logic [AXI_LEN_W-1:0] r_cnt;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_awvalid;
   logic                 r_arvalid;
   logic                 r_wvalid;
   logic                 r_wlast;
   logic [NUM_CH-1:0]    r_ack;

   logic [ADDR_W-1:0]    w_ptr [NUM_CH];
   logic [ADDR_W-1:0]    w_grant_ptr;
   logic [NUM_CH-1:0]    w_advance;
   logic [NUM_CH-1:0]    w_data_en;
   logic                 w_grant_wr;

   assign w_advance  = r_sel & {NUM_CH{r_state == ST_DONE}};
   assign w_grant_wr = |(bus.arb_grant & WR_MASK);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(g * CH_STRIDE);

      ch_addr_gen #(
         .ADDR_W (ADDR_W),
         .BASE   (LP_BASE),
         .SPAN   (FRAME_SPAN),
         .STEP   (ADDR_STEP)
      ) u_addr_gen (
         .i_clk       (clk),
         .i_rst_n     (rst_n),
         .i_frame_rst (bus.ch_frame_rst[g]),
         .i_advance   (w_advance[g]),
         .o_ptr       (w_ptr[g])
      );
   end

   // Pointer of the granted channel; grant is one-hot so an OR-mux suffices.
   always_comb begin
      w_grant_ptr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_grant_ptr = w_grant_ptr | (w_ptr[i] & {ADDR_W{bus.arb_grant[i]}});
      end
   end

   // Per-beat strobe to the owning channel, straight from the AXI handshake.
   always_comb begin
      w_data_en = '0;
      case (r_state)
         ST_WDATA: w_data_en = r_sel & {NUM_CH{r_wvalid & bus.axi_wready}};
         ST_RDATA: w_data_en = r_sel & {NUM_CH{bus.axi_rvalid}};
         default:  w_data_en = '0;
      endcase
   end

   // Burst FSM with registered AXI valids, wlast and ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_awvalid <= 1'b0;
         r_arvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_wlast   <= 1'b0;
         r_ack     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|bus.arb_grant) begin
                  r_sel     <= bus.arb_grant;
                  r_addr    <= w_grant_ptr;
                  r_awvalid <= w_grant_wr;
                  r_arvalid <= ~w_grant_wr;
                  r_state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (r_awvalid && bus.axi_awready) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b1;
                  r_wlast   <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= ST_WDATA;
               end else if (r_arvalid && bus.axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= ST_RDATA;
               end
            end
            ST_WDATA: begin
               if (bus.axi_wready) begin
                  if (r_cnt == BEAT_LAST) begin
                     r_wvalid <= 1'b0;
                     r_wlast  <= 1'b0;
                     r_ack    <= r_sel;
                     r_state  <= ST_DONE;
                  end else begin
                     r_cnt   <= r_cnt + 8'd1;
                     r_wlast <= ((r_cnt + 8'd1) == BEAT_LAST);
                  end
               end
            end
            ST_RDATA: begin
               // A missing rlast is tolerated: the beat count closes the burst.
               if (bus.axi_rvalid) begin
                  if (bus.axi_rlast || (r_cnt == BEAT_LAST)) begin
                     r_ack   <= r_sel;
                     r_state <= ST_DONE;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            ST_DONE: begin
               r_ack   <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.arb_req     = (r_state == ST_IDLE) ? bus.ch_req : '0;
   assign bus.ch_data_en  = w_data_en;
   assign bus.ch_ack      = r_ack;
   assign bus.axi_awaddr  = r_addr;
   assign bus.axi_araddr  = r_addr;
   assign bus.axi_awlen   = BEAT_LAST;
   assign bus.axi_arlen   = BEAT_LAST;
   assign bus.axi_awvalid = r_awvalid;
   assign bus.axi_arvalid = r_arvalid;
   assign bus.axi_wvalid  = r_wvalid;
   assign bus.axi_wlast   = r_wlast;
   assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ddr3_burst_ctrl.sv
// Scoreboard bench for ddr3_burst_ctrl: stimulus tasks queue the expected
// address/beat/ack events, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ddr3_burst_ctrl;
   import ddr3_if_pkg::*;

   localparam int ADDR_W = 28;
   localparam int BL     = 16;
   localparam int STEP   = 128;
   localparam int SPAN   = 512;
   localparam int STRIDE = 2097152;

   typedef struct {
      int          kind;   // 0 address handshake, 1 data beat, 2 ack
      int          ch;
      logic [27:0] addr;
      bit          wr;
      bit          last;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   last_beat_cyc = -10;
   exp_t sb[$];

   always #5 clk = ~clk;

   ddr3_burst_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   ddr3_burst_ctrl #(
      .ADDR_W     (ADDR_W),
      .BURST_LEN  (BL),
      .ADDR_STEP  (STEP),
      .FRAME_SPAN (SPAN),
      .CH_STRIDE  (STRIDE),
      .WR_MASK    (4'b0011)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Fixed-priority arbiter model: lowest index wins.
   assign bus.arb_grant = bus.arb_req & (~bus.arb_req + 4'd1);

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every visible DUT event consumes the oldest expectation.
   always @(negedge clk) begin
      bit   a_ev, b_ev, k_ev, ok;
      exp_t e;
      if (rst_n) begin
         a_ev = (bus.axi_awvalid & bus.axi_awready) | (bus.axi_arvalid & bus.axi_arready);
         b_ev = |bus.ch_data_en;
         k_ev = |bus.ch_ack;
         if (a_ev || b_ev || k_ev) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event cyc=%0d data_en=%b ack=%b awv=%b arv=%b",
                        cyc, bus.ch_data_en, bus.ch_ack, bus.axi_awvalid, bus.axi_arvalid);
            end else begin
               e  = sb.pop_front();
               ok = 1'b0;
               case (e.kind)
                  0: ok = a_ev && !b_ev && !k_ev &&
                          (e.wr ? (bus.axi_awvalid && !bus.axi_arvalid && bus.axi_awaddr == e.addr)
                                : (bus.axi_arvalid && !bus.axi_awvalid && bus.axi_araddr == e.addr));
                  1: ok = b_ev && !a_ev && !k_ev && (bus.ch_data_en == (4'b0001 << e.ch)) &&
                          (bus.axi_wlast == e.last);
                  2: ok = k_ev && !a_ev && !b_ev && (bus.ch_ack == (4'b0001 << e.ch)) &&
                          (cyc == last_beat_cyc + 1);
                  default: ok = 1'b0;
               endcase
               if (!ok) begin
                  miscompares++;
                  $display("FAIL sb_event cyc=%0d required kind=%0d ch=%0d addr=%h last=%b; actual awv=%b arv=%b awaddr=%h araddr=%h data_en=%b wlast=%b ack=%b",
                           cyc, e.kind, e.ch, e.addr, e.last, bus.axi_awvalid, bus.axi_arvalid,
                           bus.axi_awaddr, bus.axi_araddr, bus.ch_data_en, bus.axi_wlast, bus.ch_ack);
               end
            end
            if (b_ev) last_beat_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h", name, got, expv);
      end
   endtask

   task automatic push_burst(input int ch, input bit wr, input logic [27:0] a, input int beats);
      sb.push_back('{kind: 0, ch: ch, addr: a, wr: wr, last: 1'b0});
      for (int i = 0; i < beats; i++)
         sb.push_back('{kind: 1, ch: ch, addr: 28'h0, wr: wr, last: wr && (i == BL - 1)});
      if (beats == BL)
         sb.push_back('{kind: 2, ch: ch, addr: 28'h0, wr: wr, last: 1'b0});
   endtask

   task automatic wait_valid(input bit wr);
      int n;
      for (n = 0; n < 50; n++) begin
         tick();
         if (wr ? bus.axi_awvalid : bus.axi_arvalid) break;
      end
      check(wr ? "awvalid_seen" : "arvalid_seen", 64'(n < 50), 64'd1);
   endtask

   task automatic wait_ack(input int ch);
      int n;
      for (n = 0; n < 100 && !bus.ch_ack[ch]; n++) tick();
      check("ack_seen", 64'(bus.ch_ack[ch]), 64'd1);
   endtask

   task automatic wr_burst(input int ch, input int aw_wait, input bit frst, input logic [27:0] a);
      push_burst(ch, 1'b1, a, BL);
      bus.axi_wready = 1'b1;
      bus.ch_req[ch] = 1'b1;
      wait_valid(1'b1);
      repeat (aw_wait) tick();
      bus.axi_awready = 1'b1;
      tick();
      bus.axi_awready = 1'b0;
      wait_ack(ch);
      bus.ch_req[ch] = 1'b0;
      if (frst) begin
         bus.ch_frame_rst[ch] = 1'b1;
         tick();
         bus.ch_frame_rst[ch] = 1'b0;
      end
   endtask

   task automatic rd_burst(input int ch, input int ar_wait, input bit toggle, input bit send_rlast,
                           input logic [27:0] a);
      push_burst(ch, 1'b0, a, BL);
      bus.ch_req[ch] = 1'b1;
      wait_valid(1'b0);
      repeat (ar_wait) tick();
      bus.axi_arready = 1'b1;
      tick();
      bus.axi_arready = 1'b0;
      for (int b = 0; b < BL; b++) begin
         bus.axi_rvalid = 1'b1;
         bus.axi_rlast  = send_rlast && (b == BL - 1);
         tick();
         bus.axi_rvalid = 1'b0;
         bus.axi_rlast  = 1'b0;
         if (toggle && b != BL - 1) tick();
      end
      check("done_after_last_beat", {62'd0, bus.busy, bus.ch_ack[ch]}, 64'd3);
      bus.ch_req[ch] = 1'b0;
      tick();
      check("busy_low_2_after_last", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ch_req       = 4'b0000;
      bus.ch_frame_rst = 4'b0000;
      bus.axi_awready  = 1'b0;
      bus.axi_arready  = 1'b0;
      bus.axi_wready   = 1'b0;
      bus.axi_rvalid   = 1'b0;
      bus.axi_rlast    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {bus.axi_awvalid, bus.axi_arvalid, bus.axi_wvalid, bus.axi_wlast,
                              bus.ch_data_en, bus.ch_ack, bus.busy, bus.arb_req, bus.axi_awaddr},
            64'd0);
      check("awlen_const", 64'(bus.axi_awlen), 64'd15);
      check("arlen_const", 64'(bus.axi_arlen), 64'd15);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single write bursts on ch0 with delayed awready.
      wr_burst(0, 2, 1'b0, 28'h000_0000);
      wr_burst(0, 0, 1'b0, 28'h000_0080);

      // ch3 requests mid-burst: ch0 finishes first, arb_req muted while busy.
      fork
         wr_burst(0, 0, 1'b0, 28'h000_0100);
         begin
            repeat (6) tick();
            bus.ch_req[3] = 1'b1;
            tick();
            check("arb_req_muted_busy", {59'd0, bus.busy, bus.arb_req}, 64'h10);
         end
      join
      rd_burst(3, 1, 1'b1, 1'b1, 28'h060_0000);

      // Wrap on ch1 (span = 4 steps).
      wr_burst(1, 0, 1'b0, 28'h020_0000);
      wr_burst(1, 1, 1'b0, 28'h020_0080);
      wr_burst(1, 0, 1'b0, 28'h020_0100);
      wr_burst(1, 0, 1'b0, 28'h020_0180);
      wr_burst(1, 0, 1'b0, 28'h020_0000);

      // Frame reset coinciding with DONE wins over the advance.
      wr_burst(1, 0, 1'b1, 28'h020_0080);
      wr_burst(1, 0, 1'b0, 28'h020_0000);

      // ch2 reads, second without rlast; then frame reset while idle.
      rd_burst(2, 0, 1'b0, 1'b1, 28'h040_0000);
      rd_burst(2, 0, 1'b0, 1'b0, 28'h040_0080);
      bus.ch_frame_rst[2] = 1'b1;
      tick();
      bus.ch_frame_rst[2] = 1'b0;
      tick();
      rd_burst(2, 0, 1'b0, 1'b1, 28'h040_0000);

      // Async reset during write beat 7 of a ch0 burst.
      push_burst(0, 1'b1, 28'h000_0180, 7);
      bus.axi_wready = 1'b1;
      bus.ch_req[0]  = 1'b1;
      wait_valid(1'b1);
      bus.axi_awready = 1'b1;
      tick();
      bus.axi_awready = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      bus.ch_req = 4'b0000;
      rst_n      = 1'b0;
      #1;
      check("async_reset_outputs", {bus.axi_awvalid, bus.axi_arvalid, bus.axi_wvalid, bus.axi_wlast,
                                    bus.ch_data_en, bus.ch_ack, bus.busy, bus.arb_req, bus.axi_awaddr},
            64'd0);
      @(negedge clk);
      check("sb_drained_at_reset", 64'(sb.size()), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Pointers are back at their bases.
      wr_burst(0, 0, 1'b0, 28'h000_0000);
      rd_burst(2, 0, 1'b1, 1'b1, 28'h040_0000);
      wr_burst(1, 0, 1'b0, 28'h020_0000);

      repeat (3) tick();
      check("sb_empty_at_end", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ddr3_burst_ctrl.md
# ddr3_burst_ctrl

Burst sequencer downstream of the 4-way fixed-priority DDR3 arbiter. It presents channel requests to the arbiter and latches the one-hot grant. It then runs one fixed-length AXI burst (write for camera channels, read for HDMI channels) against the DDR3 controller, returns per-beat data strobes and a completion pulse to the owning channel, and keeps a per-channel wrapping frame-buffer address pointer.

## Interface
- ADDR_W, 28: AXI address width.
- BURST_LEN, 16: beats per burst (2..256); AXI len = BURST_LEN-1.
- ADDR_STEP, 128: address increment per completed burst.
- FRAME_SPAN, 2^21: address span of one channel's frame buffer; a multiple of ADDR_STEP.
- CHn_BASE (n=0..3), n*2^21: per-channel base address.
- WR_MASK, 4'b0011: channel is a write channel where its bit is 1, otherwise a read channel.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ch_req  in  4  per-channel burst request, level; held until ch_ack.
- ch_frame_rst  in  4  per-channel pulse that returns the pointer to CHn_BASE.
- arb_req  out  4  request vector to arbiter.
- arb_grant  in  4  one-hot (or zero) grant from arbiter, combinational from arb_req.
- ch_data_en  out  4  per-beat strobe to the owning channel's FIFO.
- ch_ack  out  4  one-cycle burst-complete pulse.
- axi_awaddr/axi_araddr  out  ADDR_W  burst start address.
- axi_awlen/axi_arlen  out  8  constant BURST_LEN-1.
- axi_awvalid, axi_arvalid  out  1; axi_awready, axi_arready  in  1.
- axi_wvalid, axi_wlast  out  1; axi_wready  in  1.
- axi_rvalid, axi_rlast  in  1.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ADDR, WDATA, RDATA, DONE.
- **IDLE:**
  - arb_req = ch_req; all other arb_req cycles drive 0.
  - If arb_grant is non-zero, register sel = arb_grant and latch the address from that channel's pointer, then go to ADDR.
- **ADDR:**
  - Drive axi_awvalid if sel&WR_MASK, else axi_arvalid. The address is held stable.
  - On ready, go to WDATA or RDATA and clear the beat counter.
- **WDATA:**
  - axi_wvalid = 1; the channel FIFO is guaranteed non-empty by its request.
  - ch_data_en[sel] = axi_wvalid & axi_wready.
  - axi_wlast = (cnt == BURST_LEN-1).
  - The counter increments on each handshake. The last handshake goes to DONE.
- **RDATA:**
  - ch_data_en[sel] = axi_rvalid.
  - The counter increments on each beat.
  - The burst ends on axi_rvalid & axi_rlast, or on cnt == BURST_LEN-1 if rlast never arrives, and then goes to DONE.
- **DONE:**
  - ch_ack[sel] = 1 for one cycle.
  - The pointer of sel advances by ADDR_STEP. It wraps to CHn_BASE when the next value would be ≥ CHn_BASE + FRAME_SPAN.
  - Go to IDLE.
- **Frame reset:**
  - ch_frame_rst[n] sets pointer n to CHn_BASE on the next edge, in any state.
  - If it coincides with DONE for the same channel, the frame reset wins (pointer = base, no increment).
  - An in-flight burst keeps its latched address.
- A grant with a zero ch_req bit is impossible by construction; zero grant stays in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, sel 0, counter 0, pointers = CHn_BASE. axi_*len are constant.
- **Reset mid-burst:** the burst is abandoned immediately with no drain. rst_n is shared with the DDR controller.
- **Latencies:**
  - Grant sampled in IDLE → axi_*valid asserted on the next cycle.
  - Last data beat → ch_ack on the next cycle → IDLE the cycle after.
  - Minimum burst-to-burst gap: 1 IDLE cycle.
- **Outputs:** axi_*valid, wlast and ch_ack are registered. ch_data_en is combinational from AXI ready/valid.
- **Burst length:** a write burst takes exactly BURST_LEN wready handshakes. A read burst takes BURST_LEN rvalid beats.
- **Arbitration:** priority takes effect only at burst boundaries; bursts are never pre-empted.

## Structure
- **Shared package ddr3_if_pkg:** state enum, AXI len width, and the default BURST_LEN / ADDR_STEP / FRAME_SPAN constants.
- **Sub-module ch_addr_gen, one instance per channel:**
  - Inputs: base/span parameters, frame_rst, advance.
  - Output: registered pointer.
- **Top level:** FSM, beat counter, sel register and output muxing.

## Test plan
- **Single write burst:** ch_req=0001, awready after 2 cycles, wready always 1.
  - Expected: awaddr=CH0_BASE, 16 ch_data_en[0] pulses, wlast on the 16th, ch_ack[0] one cycle after.
  - Second burst address = CH0_BASE+128.
- **Priority plus no pre-emption:** ch_req=0001 bursting, then ch_req[3] asserts mid-burst.
  - Expected: ch0 burst completes unchanged; next burst is ch3 read with araddr=CH3_BASE. arb_req=0 while busy.
- **Read with backpressure:** rvalid toggles 1/0 and rlast arrives on beat 16.
  - Expected: exactly 16 ch_data_en[3] pulses, ch_ack[3], busy low 2 cycles after rlast.
- **Wrap:** FRAME_SPAN=4*ADDR_STEP, run 5 bursts on ch1.
  - Expected addresses: base, +128, +256, +384, base.
- **Frame reset:**
  - ch_frame_rst[1] during ch1's DONE cycle → next address = CH1_BASE.
  - ch_frame_rst[2] while idle → pointer = CH2_BASE.
- **Async reset mid-WDATA (beat 7):**
  - Expected: all outputs 0 immediately, pointers = bases.
  - After release, a fresh burst starts from base.
